mem_responder: RTL and testbench

Memory-side responder for the core's instruction-fetch and data-memory ports. It serves both ports from one word-organised RAM with per-bit write masking. It also decodes a small MMIO window: a console transmit FIFO, a 64-bit cycle counter and a halt register. It sits directly opposite the core in the simulation/FPGA top level, driven by the core's `o_inst_*` and `o_mem_*` outputs.

---
 rtl/mem_responder.sv | 113 +++++++++++
 tb/tb_mem_responder.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// mem_responder: shared fetch/data RAM with per-bit write mask plus MMIO console, cycle counter and halt.
// Define MEMRESP_CONSOLE_EN to build the console FIFO, STATUS register and console stream ports.
module mem_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h80000000,
  parameter int          DEPTH_WORDS = 16384,
  parameter logic [31:0] MMIO_BASE   = 32'h10000000,
  parameter int          FIFO_DEPTH  = 8
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_inst_raddr,
  input  logic        i_inst_re,
  output logic [31:0] o_inst_rdata,
  input  logic [31:0] i_mem_addr,
  input  logic [31:0] i_mem_wdata,
  input  logic [31:0] i_mem_wmask,
  input  logic        i_mem_we,
  output logic [31:0] o_mem_rdata,
  output logic        o_con_valid,
  output logic [7:0]  o_con_data,
  input  logic        i_con_ready,
  output logic        o_halt,
  output logic [31:0] o_halt_code,
  output logic        o_fault
);
  localparam int          AW        = $clog2(DEPTH_WORDS);
  localparam logic [31:0] RAM_BYTES = 32'(4 * DEPTH_WORDS);
  localparam logic [31:0] NOP       = 32'h00000013;

  logic [31:0] r_mem [DEPTH_WORDS];
  logic [63:0] r_cyc;
  logic [31:0] w_ioff, w_doff, w_moff, w_status, w_mmio_rd;
  logic [AW-1:0] w_iidx, w_didx;
  logic w_ihit, w_dhit, w_mhit;

  assign w_ioff = i_inst_raddr - BASE_ADDR;
  assign w_doff = i_mem_addr - BASE_ADDR;
  assign w_moff = i_mem_addr - MMIO_BASE;
  assign w_ihit = w_ioff < RAM_BYTES;
  assign w_dhit = w_doff < RAM_BYTES;
  assign w_mhit = w_moff < 32'd32;
  assign w_iidx = w_ioff[AW+1:2];
  assign w_didx = w_doff[AW+1:2];

  always_comb begin
    w_mmio_rd = i_mem_addr[4:2] == 3'd1 ? w_status :
                i_mem_addr[4:2] == 3'd2 ? r_cyc[31:0] :
                i_mem_addr[4:2] == 3'd3 ? r_cyc[63:32] : 32'h0;
    o_mem_rdata = w_dhit ? r_mem[w_didx] : w_mhit ? w_mmio_rd : 32'h0;
  end

  // RAM write sits in the else branch so a write presented while reset is low is dropped.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_inst_rdata <= NOP;
      r_cyc        <= 64'h0;
      o_halt       <= 1'b0;
      o_halt_code  <= 32'h0;
      o_fault      <= 1'b0;
    end else begin
      r_cyc <= r_cyc + 64'd1;
      if (i_inst_re)
        o_inst_rdata <= w_ihit ? r_mem[w_iidx] : NOP;
      if (i_mem_we && w_dhit)
        r_mem[w_didx] <= (r_mem[w_didx] & ~i_mem_wmask) | (i_mem_wdata & i_mem_wmask);
      if (i_mem_we && w_mhit && i_mem_addr[4:2] == 3'd4 && !o_halt) begin
        o_halt      <= 1'b1;
        o_halt_code <= i_mem_wdata;
      end
      if ((i_inst_re && !w_ihit) || (i_mem_we && !w_dhit && !w_mhit))
        o_fault <= 1'b1;
    end
  end

`ifdef MEMRESP_CONSOLE_EN
  localparam int FW = $clog2(FIFO_DEPTH);
  logic [7:0] r_fifo [FIFO_DEPTH];
  logic [FW:0] r_wp, r_rp, w_cnt;
  logic r_ovf, w_full, w_push_req, w_pop, w_push;

  assign w_cnt       = r_wp - r_rp;
  assign w_full      = w_cnt == (FW+1)'(FIFO_DEPTH);
  assign o_con_valid = w_cnt != '0;
  assign o_con_data  = o_con_valid ? r_fifo[r_rp[FW-1:0]] : 8'h0;
  assign w_pop       = o_con_valid && i_con_ready;
  assign w_push_req  = i_mem_we && w_mhit && i_mem_addr[4:2] == 3'd0 && |i_mem_wmask[7:0];
  assign w_push      = w_push_req && (!w_full || w_pop);
  assign w_status    = {16'h0, 8'(w_cnt), 6'h0, r_ovf, w_full};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_ovf <= 1'b0;
    end else begin
      if (w_push) begin
        r_fifo[r_wp[FW-1:0]] <= i_mem_wdata[7:0];
        r_wp <= r_wp + 1'b1;
      end
      if (w_pop)
        r_rp <= r_rp + 1'b1;
      if (w_push_req && w_full && !w_pop)
        r_ovf <= 1'b1;
    end
  end
`else
  logic w_unused;
  assign w_unused    = i_con_ready;
  assign o_con_valid = 1'b0;
  assign o_con_data  = 8'h0;
  assign w_status    = 32'h0;
`endif
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed checks of fetch, masked writes, MMIO console/halt/counter, faults and reset.
module tb_mem_responder;
  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic [31:0] i_inst_raddr = '0;
  logic        i_inst_re = 1'b0;
  logic [31:0] o_inst_rdata;
  logic [31:0] i_mem_addr = '0;
  logic [31:0] i_mem_wdata = '0;
  logic [31:0] i_mem_wmask = '0;
  logic        i_mem_we = 1'b0;
  logic [31:0] o_mem_rdata;
  logic        o_con_valid;
  logic [7:0]  o_con_data;
  logic        i_con_ready = 1'b0;
  logic        o_halt;
  logic [31:0] o_halt_code;
  logic        o_fault;
  int vecs = 0;
  int errs = 0;

  mem_responder dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_inst_raddr(i_inst_raddr), .i_inst_re(i_inst_re), .o_inst_rdata(o_inst_rdata),
    .i_mem_addr(i_mem_addr), .i_mem_wdata(i_mem_wdata), .i_mem_wmask(i_mem_wmask),
    .i_mem_we(i_mem_we), .o_mem_rdata(o_mem_rdata),
    .o_con_valid(o_con_valid), .o_con_data(o_con_data), .i_con_ready(i_con_ready),
    .o_halt(o_halt), .o_halt_code(o_halt_code), .o_fault(o_fault)
  );

  always #5 i_clk = ~i_clk;

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [31:0] m);
    i_mem_addr = a; i_mem_wdata = d; i_mem_wmask = m; i_mem_we = 1'b1;
    @(negedge i_clk);
    i_mem_we = 1'b0;
  endtask

  task automatic test_reset;
    i_rst_n = 1'b0;
    repeat (2) @(negedge i_clk);
    vecs++;
    if ({o_inst_rdata, o_con_valid, o_con_data, o_halt, o_halt_code, o_fault} !==
        {32'h00000013, 1'b0, 8'h00, 1'b0, 32'h0, 1'b0}) begin
      errs++;
      $display("FAIL reset_outputs: got inst=%h cv=%b cd=%h h=%b hc=%h f=%b, want 13/0/00/0/0/0",
               o_inst_rdata, o_con_valid, o_con_data, o_halt, o_halt_code, o_fault);
    end
    i_rst_n = 1'b1;
  endtask

  task automatic test_cycle;
    repeat (10) @(negedge i_clk);
    i_mem_addr = 32'h10000008; #1;
    vecs++;
    if (o_mem_rdata !== 32'd10) begin errs++; $display("FAIL cycle_lo: got %0d want 10", o_mem_rdata); end
    i_mem_addr = 32'h1000000C; #1;
    vecs++;
    if (o_mem_rdata !== 32'd0) begin errs++; $display("FAIL cycle_hi: got %h want 0", o_mem_rdata); end
    @(negedge i_clk);
  endtask

  task automatic test_fetch;
    dut.r_mem[0] = 32'h00500093;
    dut.r_mem[1] = 32'hDEADBEEF;
    dut.r_mem[16383] = 32'hCAFEF00D;
    i_inst_raddr = 32'h80000000; i_inst_re = 1'b1;
    @(negedge i_clk);
    vecs++;
    if (o_inst_rdata !== 32'h00500093) begin errs++; $display("FAIL fetch_word0: got %h want 00500093", o_inst_rdata); end
    i_inst_raddr = 32'h80000004; i_inst_re = 1'b0;
    @(negedge i_clk);
    vecs++;
    if (o_inst_rdata !== 32'h00500093) begin errs++; $display("FAIL fetch_hold: got %h want 00500093", o_inst_rdata); end
    i_inst_raddr = 32'h8000FFFC; i_inst_re = 1'b1;
    @(negedge i_clk);
    i_inst_re = 1'b0;
    vecs++;
    if (o_inst_rdata !== 32'hCAFEF00D) begin errs++; $display("FAIL fetch_last_word: got %h want cafef00d", o_inst_rdata); end
  endtask

  task automatic test_write_mask;
    dut.r_mem[1] = 32'h11223344;
    dut.r_mem[2] = 32'hAAAAAAAA;
    wr(32'h80000004, 32'h00AB0000, 32'h00FF0000);
    i_mem_addr = 32'h80000004; #1;
    vecs++;
    if (o_mem_rdata !== 32'h11AB3344) begin errs++; $display("FAIL masked_write: got %h want 11ab3344", o_mem_rdata); end
    i_inst_raddr = 32'h80000008; i_inst_re = 1'b1;
    wr(32'h80000008, 32'h55555555, 32'hFFFFFFFF);
    i_inst_re = 1'b0;
    i_mem_addr = 32'h80000008; #1;
    vecs++;
    if (o_inst_rdata !== 32'hAAAAAAAA) begin errs++; $display("FAIL read_before_write: got %h want aaaaaaaa", o_inst_rdata); end
    vecs++;
    if (o_mem_rdata !== 32'h55555555) begin errs++; $display("FAIL full_write: got %h want 55555555", o_mem_rdata); end
    i_mem_addr = 32'h00000000; #1;
    vecs++;
    if ({o_mem_rdata, o_fault} !== {32'h0, 1'b0}) begin
      errs++; $display("FAIL unmapped_read: got data=%h fault=%b want 0/0", o_mem_rdata, o_fault);
    end
  endtask

  task automatic test_console;
`ifdef MEMRESP_CONSOLE_EN
    i_con_ready = 1'b0;
    for (int i = 0; i < 9; i++) wr(32'h10000000, 32'(65 + i), 32'h000000FF);
    i_mem_addr = 32'h10000004; #1;
    vecs++;
    if (o_mem_rdata !== 32'h00000803) begin errs++; $display("FAIL status_full: got %h want 00000803", o_mem_rdata); end
    i_con_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      vecs++;
      if ({o_con_valid, o_con_data} !== {1'b1, 8'(65 + i)}) begin
        errs++; $display("FAIL stream_%0d: got v=%b d=%h want 1/%h", i, o_con_valid, o_con_data, 8'(65 + i));
      end
      @(negedge i_clk);
    end
    #1;
    vecs++;
    if (o_con_valid !== 1'b0 || o_mem_rdata !== 32'h00000002) begin
      errs++; $display("FAIL drained: got v=%b status=%h want 0/00000002", o_con_valid, o_mem_rdata);
    end
    i_con_ready = 1'b0;
    i_mem_addr = 32'h10000000; i_mem_wdata = 32'h5A; i_mem_wmask = 32'hFF; i_mem_we = 1'b1; #1;
    vecs++;
    if (o_con_valid !== 1'b0) begin errs++; $display("FAIL no_bypass: got v=%b want 0", o_con_valid); end
    @(negedge i_clk);
    i_mem_we = 1'b0;
    vecs++;
    if ({o_con_valid, o_con_data} !== {1'b1, 8'h5A}) begin
      errs++; $display("FAIL push_empty: got v=%b d=%h want 1/5a", o_con_valid, o_con_data);
    end
`else
    wr(32'h10000000, 32'h41, 32'h000000FF);
    i_mem_addr = 32'h10000004; #1;
    vecs++;
    if ({o_con_valid, o_con_data, o_mem_rdata, o_fault} !== {1'b0, 8'h0, 32'h0, 1'b0}) begin
      errs++; $display("FAIL console_off: got v=%b d=%h status=%h fault=%b want 0/0/0/0",
                       o_con_valid, o_con_data, o_mem_rdata, o_fault);
    end
`endif
  endtask

  task automatic test_halt_fault;
    wr(32'h10000010, 32'h1, 32'hFFFFFFFF);
    wr(32'h10000010, 32'h2, 32'hFFFFFFFF);
    vecs++;
    if ({o_halt, o_halt_code} !== {1'b1, 32'h1}) begin
      errs++; $display("FAIL halt_sticky: got h=%b code=%h want 1/1", o_halt, o_halt_code);
    end
    wr(32'h10000014, 32'h77, 32'hFFFFFFFF);
    vecs++;
    if (o_fault !== 1'b0) begin errs++; $display("FAIL reserved_no_fault: got %b want 0", o_fault); end
    wr(32'h00000000, 32'h1, 32'hFFFFFFFF);
    vecs++;
    if (o_fault !== 1'b1) begin errs++; $display("FAIL write_fault: got %b want 1", o_fault); end
  endtask

  task automatic test_reset_mid;
    i_con_ready = 1'b1;
    i_mem_addr = 32'h80000004; i_mem_wdata = 32'hFFFFFFFF; i_mem_wmask = 32'hFFFFFFFF; i_mem_we = 1'b1;
    #2 i_rst_n = 1'b0;
    #1;
    vecs++;
    if ({o_inst_rdata, o_con_valid, o_con_data, o_halt, o_halt_code, o_fault} !==
        {32'h00000013, 1'b0, 8'h00, 1'b0, 32'h0, 1'b0}) begin
      errs++;
      $display("FAIL reset_async: got inst=%h cv=%b cd=%h h=%b hc=%h f=%b, want 13/0/00/0/0/0",
               o_inst_rdata, o_con_valid, o_con_data, o_halt, o_halt_code, o_fault);
    end
    @(negedge i_clk);
    i_mem_we = 1'b0; i_con_ready = 1'b0; #1;
    vecs++;
    if (o_mem_rdata !== 32'h11AB3344) begin errs++; $display("FAIL ram_kept: got %h want 11ab3344", o_mem_rdata); end
    i_rst_n = 1'b1;
    i_mem_addr = 32'h10000008; #1;
    vecs++;
    if (o_mem_rdata !== 32'd0) begin errs++; $display("FAIL cycle_first: got %0d want 0", o_mem_rdata); end
    @(negedge i_clk);
    vecs++;
    if (o_mem_rdata !== 32'd1) begin errs++; $display("FAIL cycle_second: got %0d want 1", o_mem_rdata); end
  endtask

  task automatic test_fetch_fault;
    i_inst_raddr = 32'h80000000; i_inst_re = 1'b1;
    @(negedge i_clk);
    i_inst_raddr = 32'h80010000;
    @(negedge i_clk);
    i_inst_re = 1'b0;
    vecs++;
    if ({o_inst_rdata, o_fault} !== {32'h00000013, 1'b1}) begin
      errs++; $display("FAIL fetch_oob: got inst=%h fault=%b want 00000013/1", o_inst_rdata, o_fault);
    end
  endtask

  initial begin
    @(negedge i_clk);
    test_reset;
    test_cycle;
    test_fetch;
    test_write_mask;
    test_console;
    test_halt_fault;
    test_reset_mid;
    test_fetch_fault;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
